// File: rtl/parallel_serializer_pkg.sv
// Shared types and default sizing for the parallel-to-serial frame converter.
package parallel_serializer_pkg;

    // Default frame geometry: words per frame and bits per word
    localparam int unsigned DEFAULT_N    = 8;
    localparam int unsigned DEFAULT_SIZE = 8;

    // IDLE: no frame held; SHIFT: frame held, words still pending
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/parallel_serializer_frame_counter.sv
// Word index within a frame: clearable up-counter with terminal-count flag.
module frame_counter #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] count,
    output logic                 tc_c
);

    localparam int unsigned CW = $clog2(N);

    // Terminal count marks the last word of the frame
    assign tc_c = (count == CW'(N - 1));

    // Clear wins over increment so a reload on the last word restarts at 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            if (tc_c) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/parallel_serializer.sv
// Frame-to-word serializer: loads N words of SIZE bits in parallel and emits
// them MSB word first over a valid/ready stream, with out_last on word N-1.
// Optional build macro PARALLEL_SERIALIZER_BACK2BACK_EN lets a new frame load
// on the final word's handshake so consecutive frames stream without a bubble.
module parallel_serializer
    import parallel_serializer_pkg::*;
#(
    parameter int unsigned N    = DEFAULT_N,
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*SIZE-1:0] parallel_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE-1:0]   serial_out,
    output logic              out_last
);

    localparam int unsigned W  = N * SIZE;
    localparam int unsigned CW = $clog2(N);

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    shreg_q;
    logic [CW-1:0]   cnt;
    logic            cnt_tc;
    logic            load;
    logic            out_hs;
    logic            out_valid_q;
    logic            out_valid_d;
    logic            out_last_q;
    logic            out_last_d;

`ifdef PARALLEL_SERIALIZER_BACK2BACK_EN
    // Accept while idle, or on the last word's handshake to chain frames
    assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_tc && out_ready);
`else
    // Accept only while idle; frames are separated by at least one idle cycle
    assign in_ready = (state_q == IDLE);
`endif

    assign load   = in_valid && in_ready;
    assign out_hs = out_valid_q && out_ready;

    // Word index within the current frame
    frame_counter #(
        .N (N)
    ) u_frame_counter (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .inc   (out_hs),
        .count (cnt),
        .tc_c  (cnt_tc)
    );

    // State register together with the registered stream flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next state and next values of out_valid / out_last
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d     = SHIFT;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (load) begin
                    // Reload on the last word: restart at word 0 of the new frame
                    state_d     = SHIFT;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                end else if (out_hs) begin
                    if (cnt_tc) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        // Counter is about to reach N-1
                        out_last_d = (cnt == CW'(N - 2));
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // Frame register: parallel load, or shift left one word with zero fill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= parallel_in;
        end else if (out_hs) begin
            shreg_q <= {shreg_q[W-SIZE-1:0], SIZE'(0)};
        end
    end

    assign serial_out = shreg_q[W-1 -: SIZE];
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;

endmodule
